// File: rtl/m_cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause bit positions,
// exception codes and register packing helpers.
package cp0_defs;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v = 32'h0000_0000;
        v[SR_IM_HI:SR_IM_LO] = im;
        v[SR_EXL] = exl;
        v[SR_IE] = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v = 32'h0000_0000;
        v[CAUSE_BD] = bd;
        v[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
        return v;
    endfunction

endpackage

// File: rtl/m_cp0_timer.sv
// CP0 Count/Compare timer; TI is sticky until software rewrites Compare.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_defs::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_din,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Count/Compare/TI state; a Compare write wins over a simultaneous match
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count   <= 32'h0000_0000;
            r_compare <= 32'h0000_0000;
            r_ti      <= 1'b0;
        end else begin
            if (i_we && (i_addr == REG_COUNT)) begin
                r_count <= i_din;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (i_we && (i_addr == REG_COMPARE)) begin
                r_compare <= i_din;
                r_ti      <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != 32'h0000_0000)) begin
                r_ti <= 1'b1;
            end else begin
                r_ti <= r_ti;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/m_cp0.sv
// M-stage CP0: SR/Cause/EPC/PRId, mtc0/mfc0/eret, exception/interrupt request.
// Optional Count/Compare timer on HWInt[5] when CP0_TIMER_EN is defined.
module m_cp0
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_8001,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic        EXLClr,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_ExcCode,
    input  logic [5:0]  HWInt,
    output logic        Req,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic [5:0]  w_hwint_eff;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_epc_exc;
    logic [31:0] w_dout;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;

    cp0_timer u_timer (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_we      (WE & ~w_req),
        .i_addr    (A2),
        .i_din     (DIn),
        .o_count   (w_count),
        .o_compare (w_compare),
        .o_ti      (w_ti)
    );

    assign w_hwint_eff = {HWInt[5] | w_ti, HWInt[4:0]};
`else
    assign w_hwint_eff = HWInt;
`endif

    assign w_int_req = r_ie & ~r_exl & (|(w_hwint_eff & r_im));
    assign w_exc_req = ~r_exl & (M_ExcCode != 5'd0);
    assign w_req     = (w_int_req | w_exc_req) & ~reset;
    // Delay-slot victims restart at the branch; the subtraction wraps at 0
    assign w_epc_exc = M_PC - (M_BD ? 32'd4 : 32'd0);

    // Architectural CP0 state; exception entry pre-empts mtc0 and eret
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'h0000_0000;
        end else begin
            r_ip <= w_hwint_eff;
            if (w_req) begin
                r_exl     <= 1'b1;
                r_bd      <= M_BD;
                r_exccode <= w_int_req ? EXC_INT : M_ExcCode;
                r_epc     <= w_epc_exc & 32'hFFFF_FFFC;
            end else begin
                if (WE && (A2 == REG_SR)) begin
                    r_im  <= DIn[SR_IM_HI:SR_IM_LO];
                    r_exl <= DIn[SR_EXL] & ~EXLClr;
                    r_ie  <= DIn[SR_IE];
                end else if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (WE && (A2 == REG_EPC)) begin
                    r_epc <= DIn & 32'hFFFF_FFFC;
                end
            end
        end
    end

    // mfc0 read mux over the current register values
    always_comb begin
        w_dout = 32'h0000_0000;
        case (A1)
`ifdef CP0_TIMER_EN
            REG_COUNT:   w_dout = w_count;
            REG_COMPARE: w_dout = w_compare;
`endif
            REG_SR:      w_dout = pack_sr(r_im, r_exl, r_ie);
            REG_CAUSE:   w_dout = pack_cause(r_bd, r_ip, r_exccode);
            REG_EPC:     w_dout = r_epc;
            REG_PRID:    w_dout = PRID_VALUE;
            default:     w_dout = 32'h0000_0000;
        endcase
    end

    assign Req    = w_req;
    assign DOut   = w_dout;
    assign EPCOut = r_epc;

endmodule
